// File: rtl/mhz1_pkg.sv
// mhz1_pkg: shared types and constants for the 1 MHz bus controller.
//   mhz1_state_e : controller state encoding (IDLE, REQ, SYNC, HOLD)
//   *_BASE/*_MASK: 1 MHz peripheral regions, matched as (a & MASK) == BASE
//   in_region()  : region match helper used by the address decoder
package mhz1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SYNC = 2'd2,
    ST_HOLD = 2'd3
  } mhz1_state_e;

  // &FE00-&FE1F: CRTC, ACIA, SERPROC
  localparam logic [15:0] CRTC_ACIA_BASE = 16'hFE00;
  localparam logic [15:0] CRTC_ACIA_MASK = 16'hFFE0;
  // &FE40-&FE7F: system and user VIAs
  localparam logic [15:0] VIA_BASE       = 16'hFE40;
  localparam logic [15:0] VIA_MASK       = 16'hFFC0;
  // &FEC0-&FEDF: ADC
  localparam logic [15:0] ADC_BASE       = 16'hFEC0;
  localparam logic [15:0] ADC_MASK       = 16'hFFE0;
  // &FC00-&FDFF: FRED/JIM expansion pages
  localparam logic [15:0] FRED_JIM_BASE  = 16'hFC00;
  localparam logic [15:0] FRED_JIM_MASK  = 16'hFE00;

  function automatic logic in_region(input logic [15:0] a,
                                     input logic [15:0] base,
                                     input logic [15:0] mask);
    return (a & mask) == base;
  endfunction

endpackage

// File: rtl/mhz1_addr_decode.sv
// mhz1_addr_decode: combinational 1 MHz peripheral map decode.
// Ports:
//   addr [ADDR_W-1:0] in  CPU address (low 16 bits are decoded)
//   slow              out address lies in a 1 MHz region
// Parameters:
//   ADDR_W        CPU address width (>= 16)
//   FRED_JIM_SLOW 1: &FC00-&FDFF also decoded as 1 MHz
module mhz1_addr_decode
  import mhz1_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int FRED_JIM_SLOW = 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              slow
);

  logic [15:0] addr_lo;
  logic        fred_jim;

  assign addr_lo  = addr[15:0];
  assign fred_jim = (FRED_JIM_SLOW != 0) &&
                    in_region(addr_lo, FRED_JIM_BASE, FRED_JIM_MASK);

  assign slow = in_region(addr_lo, CRTC_ACIA_BASE, CRTC_ACIA_MASK) ||
                in_region(addr_lo, VIA_BASE, VIA_MASK)             ||
                in_region(addr_lo, ADC_BASE, ADC_MASK)             ||
                fred_jim;

endmodule

// File: rtl/mhz1_bus_ctrl.sv
// mhz1_bus_ctrl: requests CPU cycle stretching for 1 MHz peripheral
// accesses and sequences one device strobe per stretched cycle.
// Ports:
//   clk_48m, reset_n  48 MHz clock, async active-low reset
//   cpu_clken         CPU advance enable (already stretched)
//   mhz2_clken        2 MHz enable (counter 23/47)
//   mhz1_clken        1 MHz enable (counter 47)
//   cpu_a, cpu_rnw    CPU address / read-not-write
//   mhz1_enable       stretch request to the clock-enable generator
//   mhz1_active       high while a 1 MHz access is in progress
//   mhz1_strobe       one-clk device strobe on the 1 MHz edge
//   mhz1_rnw/addr     access direction and address, latched at request
//   stretch_count     (only with MHZ1_STRETCH_CNT_EN) REQ entry count
// Build option: define MHZ1_STRETCH_CNT_EN to add stretch_count.
//
// state | meaning
// IDLE  | no access; looks for a slow address on the sample clk
// REQ   | stretch requested, waiting for the generator's 2 MHz edge
// SYNC  | request taken, waiting for the 1 MHz edge to strobe
// HOLD  | strobe done, waiting for the CPU to advance
module mhz1_bus_ctrl
  import mhz1_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int FRED_JIM_SLOW = 1
) (
  input  logic              clk_48m,
  input  logic              reset_n,
  input  logic              cpu_clken,
  input  logic              mhz2_clken,
  input  logic              mhz1_clken,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic              cpu_rnw,
  output logic              mhz1_enable,
  output logic              mhz1_active,
  output logic              mhz1_strobe,
  output logic              mhz1_rnw,
  output logic [ADDR_W-1:0] mhz1_addr
`ifdef MHZ1_STRETCH_CNT_EN
  ,
  output logic [15:0]       stretch_count
`endif
);

  mhz1_state_e       state_q, state_d;
  logic              samp_q;
  logic              is_slow;
  logic              enable_d;
  logic              active_d;
  logic              rnw_d;
  logic [ADDR_W-1:0] addr_d;

  mhz1_addr_decode #(
    .ADDR_W       (ADDR_W),
    .FRED_JIM_SLOW(FRED_JIM_SLOW)
  ) u_decode (
    .addr(cpu_a),
    .slow(is_slow)
  );

  always_ff @(posedge clk_48m or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      samp_q      <= 1'b0;
      mhz1_enable <= 1'b0;
      mhz1_active <= 1'b0;
      mhz1_rnw    <= 1'b0;
      mhz1_addr   <= '0;
    end else begin
      state_q     <= state_d;
      // The address is settled one clk after the CPU advanced.
      samp_q      <= cpu_clken;
      mhz1_enable <= enable_d;
      mhz1_active <= active_d;
      mhz1_rnw    <= rnw_d;
      mhz1_addr   <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    enable_d    = mhz1_enable;
    active_d    = mhz1_active;
    rnw_d       = mhz1_rnw;
    addr_d      = mhz1_addr;
    mhz1_strobe = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (samp_q && is_slow) begin
          state_d  = ST_REQ;
          enable_d = 1'b1;
          active_d = 1'b1;
          rnw_d    = cpu_rnw;
          addr_d   = cpu_a;
        end
      end
      ST_REQ: begin
        if (cpu_clken) begin
          state_d  = ST_IDLE;
          enable_d = 1'b0;
          active_d = 1'b0;
          rnw_d    = 1'b0;
          addr_d   = '0;
        end else if (mhz2_clken) begin
          // Enable stays high one more clk so the generator sees it on
          // this 2 MHz edge; it is dropped from SYNC.
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        enable_d = 1'b0;
        if (cpu_clken) begin
          state_d  = ST_IDLE;
          active_d = 1'b0;
          rnw_d    = 1'b0;
          addr_d   = '0;
        end else if (mhz1_clken) begin
          // A 1 MHz edge coinciding with REQ->SYNC entry was consumed in
          // REQ, so this is always the following 1 MHz edge.
          mhz1_strobe = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cpu_clken) begin
          state_d  = ST_IDLE;
          active_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        enable_d = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

`ifdef MHZ1_STRETCH_CNT_EN
  logic req_entry;

  assign req_entry = (state_q == ST_IDLE) && (state_d == ST_REQ);

  always_ff @(posedge clk_48m or negedge reset_n) begin
    if (!reset_n) begin
      stretch_count <= 16'd0;
    end else if (req_entry) begin
      stretch_count <= stretch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mhz1_bus_ctrl.sv
// tb_mhz1_bus_ctrl: self-checking bench for mhz1_bus_ctrl.
// Two instances share stimulus: dut1 (FRED_JIM_SLOW=1), dut0 (=0).
// Expected outputs come from a timestamp model: on each sample clk the
// bench computes, with modular arithmetic on the 48-clk phase, the clks
// at which the stretch request ends and the strobe is due.
module tb_mhz1_bus_ctrl;

  logic        clk_48m    = 1'b0;
  logic        reset_n    = 1'b0;
  logic        cpu_clken  = 1'b0;
  logic        mhz2_clken = 1'b0;
  logic        mhz1_clken = 1'b0;
  logic [15:0] cpu_a      = 16'h0000;
  logic        cpu_rnw    = 1'b0;

  logic        en1, act1, stb1, rnw1;
  logic [15:0] addr1;
  logic        en0, act0, stb0, rnw0;
  logic [15:0] addr0;
`ifdef MHZ1_STRETCH_CNT_EN
  logic [15:0] sc1, sc0;
  logic [15:0] m_cnt [2];
`endif

  always #5 clk_48m = ~clk_48m;

  mhz1_bus_ctrl #(.ADDR_W(16), .FRED_JIM_SLOW(1)) dut1 (
    .clk_48m(clk_48m), .reset_n(reset_n), .cpu_clken(cpu_clken),
    .mhz2_clken(mhz2_clken), .mhz1_clken(mhz1_clken), .cpu_a(cpu_a),
    .cpu_rnw(cpu_rnw), .mhz1_enable(en1), .mhz1_active(act1),
    .mhz1_strobe(stb1), .mhz1_rnw(rnw1), .mhz1_addr(addr1)
`ifdef MHZ1_STRETCH_CNT_EN
    , .stretch_count(sc1)
`endif
  );

  mhz1_bus_ctrl #(.ADDR_W(16), .FRED_JIM_SLOW(0)) dut0 (
    .clk_48m(clk_48m), .reset_n(reset_n), .cpu_clken(cpu_clken),
    .mhz2_clken(mhz2_clken), .mhz1_clken(mhz1_clken), .cpu_a(cpu_a),
    .cpu_rnw(cpu_rnw), .mhz1_enable(en0), .mhz1_active(act0),
    .mhz1_strobe(stb0), .mhz1_rnw(rnw0), .mhz1_addr(addr0)
`ifdef MHZ1_STRETCH_CNT_EN
    , .stretch_count(sc0)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model state, index 0 -> dut0, 1 -> dut1
  bit          m_acc     [2];
  int          m_en_last [2];
  int          m_stb     [2];
  logic [15:0] m_addr    [2];
  logic        m_rnw     [2];
  logic        prev_ck;

  // observation bookkeeping
  int   stb_seen [2];
  int   last_stb [2];
  int   stb_gap  [2];
  int   en_fall  [2];
  logic prev_en  [2];

  logic [15:0] cur_a   = 16'h0000;
  logic        cur_rnw = 1'b0;

  typedef struct {
    logic [15:0] a;
    logic        rnw;
    int          slow1;
    int          slow0;
  } vec_t;

  function automatic bit ref_slow(input logic [15:0] a, input bit fjs);
    return (a >= 16'hFE00 && a <= 16'hFE1F) ||
           (a >= 16'hFE40 && a <= 16'hFE7F) ||
           (a >= 16'hFEC0 && a <= 16'hFEDF) ||
           (fjs && a >= 16'hFC00 && a <= 16'hFDFF);
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h) cyc=%0d",
               name, got, got, want, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i]  = 1'b0;
      m_addr[i] = 16'h0000;
      m_rnw[i]  = 1'b0;
      prev_en[i] = 1'b0;
`ifdef MHZ1_STRETCH_CNT_EN
      m_cnt[i] = 16'h0000;
`endif
    end
    prev_ck = 1'b0;
  endtask

  // Compare this clk's outputs with the model, then advance the model.
  task automatic check_models();
    logic [19:0] act_v [2];
    logic [19:0] exp_v;
    logic        e_en, e_act, e_stb;
    int          j, r, q;
    act_v[0] = {en0, act0, stb0, rnw0, addr0};
    act_v[1] = {en1, act1, stb1, rnw1, addr1};
    for (int i = 0; i < 2; i++) begin
      e_act = m_acc[i];
      e_en  = m_acc[i] && (cyc <= m_en_last[i]);
      e_stb = m_acc[i] && (cyc == m_stb[i]) && !cpu_clken;
      exp_v = {e_en, e_act, e_stb, m_rnw[i], m_addr[i]};
      checks++;
      if (act_v[i] !== exp_v) begin
        failures++;
        $display("FAIL cycle_model inst%0d cyc=%0d got{en,act,stb,rnw,addr}=%h want=%h",
                 i, cyc, act_v[i], exp_v);
      end
`ifdef MHZ1_STRETCH_CNT_EN
      chk($sformatf("stretch_count_inst%0d", i),
          (i == 1) ? int'(sc1) : int'(sc0), int'(m_cnt[i]));
`endif
      if (act_v[i][17]) begin
        stb_seen[i]++;
        stb_gap[i]  = cyc - last_stb[i];
        last_stb[i] = cyc;
      end
      if (prev_en[i] && !act_v[i][19]) en_fall[i] = cyc;
      prev_en[i] = act_v[i][19];

      // CPU advancing ends any access; before the strobe it is an abort.
      if (cpu_clken && m_acc[i]) begin
        m_acc[i] = 1'b0;
        if (cyc <= m_stb[i]) begin
          m_addr[i] = 16'h0000;
          m_rnw[i]  = 1'b0;
        end
      end
      // Sample clk with a slow address: request visible from next clk.
      if (prev_ck && ref_slow(cpu_a, i == 1)) begin
        j = cyc + 1;
        r = j + (23 - (j % 24));      // first 2 MHz edge in REQ
        q = (r + 1) + (47 - ((r + 1) % 48)); // next 1 MHz edge after it
        m_acc[i]     = 1'b1;
        m_en_last[i] = r + 1;
        m_stb[i]     = q;
        m_addr[i]    = cpu_a;
        m_rnw[i]     = cpu_rnw;
`ifdef MHZ1_STRETCH_CNT_EN
        m_cnt[i] = m_cnt[i] + 16'd1;
`endif
      end
    end
    prev_ck = cpu_clken;
  endtask

  task automatic tick(input logic ck, input logic [15:0] a, input logic rnw);
    @(posedge clk_48m);
    #1;
    cyc++;
    mhz2_clken = (cyc % 24) == 23;
    mhz1_clken = (cyc % 48) == 47;
    cpu_clken  = ck;
    cpu_a      = a;
    cpu_rnw    = rnw;
    #3;
    check_models();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, cur_a, cur_rnw);
  endtask

  task automatic pulse(input logic [15:0] a, input logic rnw);
    cur_a   = a;
    cur_rnw = rnw;
    tick(1'b1, a, rnw);
  endtask

  // Advance so that the next tick lands on phase c.
  task automatic align_to(input int c);
    for (int k = 0; k < 48 && ((cyc + 1) % 48) != c; k++)
      tick(1'b0, cur_a, cur_rnw);
  endtask

  initial begin
    vec_t        vecs [16];
    int          s0, s1, p, n;
    logic [15:0] ra;

    vecs[0]  = '{16'hFE40, 1'b1, 1, 1};
    vecs[1]  = '{16'hFE28, 1'b0, 0, 0};
    vecs[2]  = '{16'hFC10, 1'b0, 1, 0};
    vecs[3]  = '{16'hFE00, 1'b1, 1, 1};
    vecs[4]  = '{16'hFE1F, 1'b0, 1, 1};
    vecs[5]  = '{16'hFE20, 1'b1, 0, 0};
    vecs[6]  = '{16'hFE3F, 1'b0, 0, 0};
    vecs[7]  = '{16'hFE7F, 1'b1, 1, 1};
    vecs[8]  = '{16'hFE80, 1'b0, 0, 0};
    vecs[9]  = '{16'hFEC0, 1'b1, 1, 1};
    vecs[10] = '{16'hFEDF, 1'b0, 1, 1};
    vecs[11] = '{16'hFEE0, 1'b1, 0, 0};
    vecs[12] = '{16'hFDFF, 1'b1, 1, 0};
    vecs[13] = '{16'hFBFF, 1'b0, 0, 0};
    vecs[14] = '{16'hFF00, 1'b1, 0, 0};
    vecs[15] = '{16'h0000, 1'b0, 0, 0};

    for (int i = 0; i < 2; i++) begin
      stb_seen[i] = 0; last_stb[i] = 0; stb_gap[i] = 0; en_fall[i] = 0;
      m_en_last[i] = 0; m_stb[i] = 0;
    end
    model_reset();

    // Reset
    idle(3);
    reset_n = 1'b1;
    idle(2);
    chk("reset_enable", int'(en1), 0);
    chk("reset_active", int'(act1), 0);
    chk("reset_addr", int'(addr1), 0);

    // Decode table: access sampled at phase 1
    for (int i = 0; i < 16; i++) begin
      s0 = stb_seen[0];
      s1 = stb_seen[1];
      align_to(0);
      pulse(vecs[i].a, vecs[i].rnw);
      idle(60);
      chk($sformatf("strobes_fjs1_%h", vecs[i].a), stb_seen[1] - s1, vecs[i].slow1);
      chk($sformatf("strobes_fjs0_%h", vecs[i].a), stb_seen[0] - s0, vecs[i].slow0);
      if (vecs[i].slow1 != 0) begin
        chk("strobe_phase", last_stb[1] % 48, 47);
        chk("enable_fall_phase", en_fall[1] % 48, 25);
        chk("latched_addr", int'(addr1), int'(vecs[i].a));
        chk("latched_rnw", int'(rnw1), int'(vecs[i].rnw));
        chk("hold_active", int'(act1), 1);
      end else begin
        chk("fast_active", int'(act1), 0);
        chk("fast_enable", int'(en1), 0);
      end
    end

    // Back-to-back &FE60 then &FE61
    align_to(0);
    pulse(16'hFE60, 1'b1);
    idle(49);
    chk("b2b_hold_addr", int'(addr1), 16'hFE60);
    pulse(16'hFE61, 1'b0);
    idle(1);
    chk("b2b_addr_at_sample", int'(addr1), 16'hFE60);
    idle(1);
    chk("b2b_addr_new", int'(addr1), 16'hFE61);
    chk("b2b_rnw_new", int'(rnw1), 0);
    idle(50);
    chk("b2b_strobe_gap", stb_gap[1], 48);

    // 2 MHz and 1 MHz edges together while in REQ
    align_to(29);
    s1 = stb_seen[1];
    p  = cyc + 1;
    pulse(16'hFE44, 1'b1);
    idle(70);
    chk("coincident_edges_strobes", stb_seen[1] - s1, 1);
    chk("coincident_edges_latency", last_stb[1] - (p + 1), 65);

    // CPU advancing during REQ, then during SYNC: abort, no strobe
    align_to(0);
    s1 = stb_seen[1];
    pulse(16'hFE00, 1'b1);
    idle(9);
    pulse(16'hFE28, 1'b0);
    idle(3);
    chk("abort_req_addr", int'(addr1), 0);
    chk("abort_req_active", int'(act1), 0);
    align_to(0);
    pulse(16'hFEC4, 1'b0);
    idle(29);
    pulse(16'hFE28, 1'b1);
    idle(60);
    chk("abort_strobes", stb_seen[1] - s1, 0);
    chk("abort_sync_enable", int'(en1), 0);

    // Reset during SYNC
    align_to(0);
    pulse(16'hFE50, 1'b1);
    idle(29);
    s1 = stb_seen[1];
    reset_n = 1'b0;
    #1;
    chk("async_reset_active", int'(act1), 0);
    chk("async_reset_addr", int'(addr1), 0);
    chk("async_reset_rnw", int'(rnw1), 0);
    model_reset();
    idle(3);
    reset_n = 1'b1;
    idle(100);
    chk("post_reset_strobes", stb_seen[1] - s1, 0);

`ifdef MHZ1_STRETCH_CNT_EN
    for (int i = 0; i < 3; i++) begin
      pulse(16'hFE08, 1'b1);
      idle(59);
    end
    chk("stretch_count_three", int'(sc1), 3);
`endif

    // Randomised CPU traffic
    for (int t = 0; t < 60; t++) begin
      n = $urandom_range(3, 110);
      idle(n - 1);
      case ($urandom_range(0, 3))
        0: ra = 16'($urandom);
        1: ra = 16'hFE00 + 16'($urandom_range(0, 255));
        2: ra = 16'hFC00 + 16'($urandom_range(0, 1023));
        default: ra = 16'hFE40 + 16'($urandom_range(0, 63));
      endcase
      pulse(ra, 1'($urandom_range(0, 1)));
    end
    idle(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
